// File: rtl/kara_pp_gen_4bit.sv
// kara_pp_gen_4bit
//   Sequential Karatsuba partial-product generator over GF(2) (carry-less).
//   Splits a and b into H-bit halves and produces the three (N-1)-bit products
//   consumed by the overlap/recombination stage:
//     pp_lo  = a_lo * b_lo
//     pp_hi  = a_hi * b_hi
//     pp_mid = (a_lo ^ a_hi) * (b_lo ^ b_hi) ^ pp_lo ^ pp_hi
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   operand handshake (a, b: N bits, bit i = coeff of x^i)
//     out_valid/out_ready result handshake (pp_lo, pp_mid, pp_hi: N-1 bits)
//   Build option:
//     KARA_PP_PARALLEL_EN  defined: three multipliers, all products registered in
//                          one cycle (1-cycle latency). Undefined: one shared
//                          multiplier stepped through LO/HI/MID (3-cycle latency).
module kara_pp_gen_4bit #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-2:0] pp_lo,
   output logic [N-2:0] pp_mid,
   output logic [N-2:0] pp_hi
);

   localparam int unsigned H = N / 2;
   localparam int unsigned P = N - 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LO   = 3'd1;
   localparam logic [2:0] S_HI   = 3'd2;
   localparam logic [2:0] S_MID  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   // Carry-less HxH multiply: XOR of shifted copies of x selected by bits of y.
   function automatic logic [P-1:0] clmul(input logic [H-1:0] x, input logic [H-1:0] y);
      logic [P-1:0] acc;
      acc = '0;
      for (int unsigned i = 0; i < H; i++) begin
         if (y[i]) acc = acc ^ (P'(x) << i);
      end
      return acc;
   endfunction

   logic [2:0]   state_q, state_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic [P-1:0] pp_lo_q, pp_lo_d;
   logic [P-1:0] pp_mid_q, pp_mid_d;
   logic [P-1:0] pp_hi_q, pp_hi_d;
   logic         out_valid_q, out_valid_d;
   logic         in_ready_q, in_ready_d;

   logic [H-1:0] a_lo, a_hi, b_lo, b_hi;
   logic [P-1:0] p_lo, p_hi, p_mid;

   assign a_lo = a_q[H-1:0];
   assign a_hi = a_q[N-1:H];
   assign b_lo = b_q[H-1:0];
   assign b_hi = b_q[N-1:H];

`ifdef KARA_PP_PARALLEL_EN
   // Dedicated multiplier per product.
   assign p_lo  = clmul(a_lo, b_lo);
   assign p_hi  = clmul(a_hi, b_hi);
   assign p_mid = clmul(a_lo ^ a_hi, b_lo ^ b_hi);
`else
   logic [H-1:0] mul_x, mul_y;
   logic [P-1:0] mul_p;

   // Operand steering for the single shared multiplier.
   always_comb begin
      mul_x = a_lo;
      mul_y = b_lo;
      case (state_q)
         S_HI: begin
            mul_x = a_hi;
            mul_y = b_hi;
         end
         S_MID: begin
            mul_x = a_lo ^ a_hi;
            mul_y = b_lo ^ b_hi;
         end
         default: begin
         end
      endcase
   end

   assign mul_p = clmul(mul_x, mul_y);
   assign p_lo  = mul_p;
   assign p_hi  = mul_p;
   assign p_mid = mul_p;
`endif

   // Next-state and datapath updates.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      pp_lo_d     = pp_lo_q;
      pp_mid_d    = pp_mid_q;
      pp_hi_d     = pp_hi_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d = a;
               b_d = b;
`ifdef KARA_PP_PARALLEL_EN
               state_d = S_MID;
`else
               state_d = S_LO;
`endif
            end
         end
         S_LO: begin
            pp_lo_d = p_lo;
            state_d = S_HI;
         end
         S_HI: begin
            pp_hi_d = p_hi;
            state_d = S_MID;
         end
         S_MID: begin
`ifdef KARA_PP_PARALLEL_EN
            pp_lo_d = p_lo;
            pp_hi_d = p_hi;
`endif
            // pp_lo_d/pp_hi_d carry this cycle's values in either build.
            pp_mid_d    = p_mid ^ pp_lo_d ^ pp_hi_d;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
      in_ready_d = (state_d == S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         pp_lo_q     <= '0;
         pp_mid_q    <= '0;
         pp_hi_q     <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         pp_lo_q     <= pp_lo_d;
         pp_mid_q    <= pp_mid_d;
         pp_hi_q     <= pp_hi_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign pp_lo     = pp_lo_q;
   assign pp_mid    = pp_mid_q;
   assign pp_hi     = pp_hi_q;

endmodule

// File: tb/tb_kara_pp_gen_4bit.sv
// Testbench for kara_pp_gen_4bit: cycle model from the handshake/latency rules,
// products from plain carry-less arithmetic, randomized sweep plus directed vectors.
module tb_kara_pp_gen_4bit;

`ifdef KARA_PP_PARALLEL_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 3;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [3:0] a = 4'd0;
   logic [3:0] b = 4'd0;
   logic       in_ready;
   logic       out_valid;
   logic [2:0] pp_lo, pp_mid, pp_hi;

   int errors = 0;
   int checks = 0;

   kara_pp_gen_4bit #(.N(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .pp_lo(pp_lo), .pp_mid(pp_mid), .pp_hi(pp_hi)
   );

   always #5 clk = ~clk;

   function automatic int clmul_ref(input int x, input int y);
      int r;
      r = 0;
      for (int i = 0; i < 16; i++) if (((y >> i) & 1) != 0) r = r ^ (x << i);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: transaction-level timing and expected products.
   bit m_valid = 1'b0;
   bit m_ready = 1'b1;
   int m_cnt = 0;
   int e_a = 0, e_b = 0, e_lo = 0, e_mid = 0, e_hi = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 1'b0;
         m_ready = 1'b1;
         m_cnt   = 0;
      end else if (m_valid) begin
         if (out_ready) begin
            m_valid = 1'b0;
            m_ready = 1'b1;
         end
      end else if (m_ready) begin
         if (in_valid) begin
            e_a   = int'(a);
            e_b   = int'(b);
            e_lo  = clmul_ref(e_a & 3, e_b & 3);
            e_hi  = clmul_ref((e_a >> 2) & 3, (e_b >> 2) & 3);
            e_mid = clmul_ref((e_a ^ (e_a >> 2)) & 3, (e_b ^ (e_b >> 2)) & 3) ^ e_lo ^ e_hi;
            m_ready = 1'b0;
            m_cnt   = LAT;
         end
      end else begin
         m_cnt--;
         if (m_cnt == 0) m_valid = 1'b1;
      end
   end

   // Per-cycle compare against the model, away from the clock edge.
   always @(posedge clk) begin
      #3;
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("in_ready", 32'(in_ready), 32'(m_ready));
      if (m_valid) begin
         check("pp_lo", 32'(pp_lo), 32'(e_lo));
         check("pp_mid", 32'(pp_mid), 32'(e_mid));
         check("pp_hi", 32'(pp_hi), 32'(e_hi));
         check("overlap", 32'(int'(pp_lo) ^ (int'(pp_mid) << 2) ^ (int'(pp_hi) << 4)),
               32'(clmul_ref(e_a, e_b)));
      end
   end

   task automatic run_txn(input logic [3:0] ta, input logic [3:0] tbv, input int stall,
                          input bit garbage, input bit lit,
                          input logic [2:0] elo, input logic [2:0] emid, input logic [2:0] ehi);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      a = ta;
      b = tbv;
      @(negedge clk);
      in_valid = garbage;
      guard = 0;
      while (!out_valid && guard < 50) begin
         out_ready = 1'($urandom);
         if (garbage) begin
            a = 4'hF;
            b = 4'($urandom);
         end
         @(negedge clk);
         guard++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("latency", 32'(guard), 32'(LAT));
      if (lit) begin
         check("lit_pp_lo", 32'(pp_lo), 32'(elo));
         check("lit_pp_mid", 32'(pp_mid), 32'(emid));
         check("lit_pp_hi", 32'(pp_hi), 32'(ehi));
      end
      repeat (stall) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         if (lit) check("stall_pp_mid", 32'(pp_mid), 32'(emid));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("release_in_ready", 32'(in_ready), 32'd1);
      check("release_out_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Pin the reference arithmetic with hand-computed products.
      check("ref_b_x_6", 32'(clmul_ref(4'hB, 4'h6)), 32'h3A);
      check("ref_f_x_f", 32'(clmul_ref(4'hF, 4'hF)), 32'h55);
      check("ref_3_x_5", 32'(clmul_ref(4'h3, 4'h5)), 32'h0F);

      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_pp", 32'({pp_lo, pp_mid, pp_hi}), 32'd0);
      rst_n = 1'b1;

      run_txn(4'hB, 4'h6, 0, 1'b0, 1'b1, 3'b110, 3'b111, 3'b010);
      run_txn(4'hF, 4'hF, 0, 1'b0, 1'b1, 3'b101, 3'b000, 3'b101);
      run_txn(4'hB, 4'h6, 10, 1'b0, 1'b1, 3'b110, 3'b111, 3'b010);
      run_txn(4'h3, 4'h5, 1, 1'b1, 1'b1, 3'b011, 3'b011, 3'b000);

      // Reset while the final product is being formed.
      @(negedge clk);
      in_valid = 1'b1;
      a = 4'hB;
      b = 4'h6;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_pp", 32'({pp_lo, pp_mid, pp_hi}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("post_rst_no_valid", 32'(out_valid), 32'd0);
      end

      for (int i = 0; i < 256; i++) begin
         run_txn(4'(i >> 4), 4'(i), int'($urandom_range(0, 3)), 1'($urandom), 1'b0,
                 3'd0, 3'd0, 3'd0);
      end

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
